// File: rtl/rat_io_pkg.sv
// rtl/rat_io_pkg.sv - RAT port-bus address map and interrupt status bit layout
package rat_io_pkg;

  localparam logic [7:0] PID_SWITCHES   = 8'h20;
  localparam logic [7:0] PID_BUTTONS    = 8'h21;
  localparam logic [7:0] PID_LEDS       = 8'h40;
  localparam logic [7:0] PID_SSEG       = 8'h81;
  localparam logic [7:0] PID_TMR_RELOAD = 8'h30;
  localparam logic [7:0] PID_INT_MASK   = 8'h31;
  localparam logic [7:0] PID_INT_STATUS = 8'h32;

  // status[0] is the timer, status[4:1] are BUTTONS[3:0] rising edges
  localparam int ST_TIMER = 0;
  localparam int ST_BTN0  = 1;
  localparam int NUM_SRC  = 5;

endpackage

// File: rtl/rat_interval_timer.sv
// rtl/rat_interval_timer.sv - prescaled 8-bit reloading down counter with expiry pulse
module rat_interval_timer #(
  parameter int PRESCALE = 50000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       LD,
  input  logic [7:0] RELOAD,
  output logic       EXPIRE
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc;
  logic [7:0]    reload_q;
  logic [7:0]    count;
  logic          tick;

  assign tick   = (presc == PW'(PRESCALE - 1));
  // Combinational so the bridge can set its status bit on the tick edge itself
  assign EXPIRE = tick && (count == 8'd1);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc    <= '0;
      reload_q <= '0;
      count    <= '0;
    end else if (LD) begin
      presc    <= '0;
      reload_q <= RELOAD;
      count    <= RELOAD;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      // A zero count means stopped: it never decrements or expires
      if (tick && (count != 8'd0)) begin
        count <= (count == 8'd1) ? reload_q : count - 8'd1;
      end
    end
  end

endmodule

// File: rtl/rat_io_bridge.sv
// rtl/rat_io_bridge.sv - RAT MCU port-bus responder: board latches, input sync, timer, interrupts
module rat_io_bridge
  import rat_io_pkg::*;
#(
  parameter int PRESCALE = 50000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] OUT_PORT,
  input  logic [7:0] PORT_ID,
  input  logic       IO_STRB,
  output logic [7:0] IN_PORT,
  output logic       INT_CU,
  input  logic [7:0] SWITCHES,
  input  logic [3:0] BUTTONS,
  output logic [7:0] LEDS,
  output logic [7:0] SSEG_VAL
);

  logic [7:0]         sw_meta, sw_sync;
  logic [3:0]         btn_meta, btn_sync, btn_hist;
  logic [7:0]         leds_q, sseg_q, reload_q;
  logic [NUM_SRC-1:0] mask_q, status_q, status_nxt;
  logic [NUM_SRC-1:0] events, w1c;
  logic               int_q, expire;
  logic               wr_leds, wr_sseg, wr_reload, wr_mask, wr_status;

  assign wr_leds   = IO_STRB && (PORT_ID == PID_LEDS);
  assign wr_sseg   = IO_STRB && (PORT_ID == PID_SSEG);
  assign wr_reload = IO_STRB && (PORT_ID == PID_TMR_RELOAD);
  assign wr_mask   = IO_STRB && (PORT_ID == PID_INT_MASK);
  assign wr_status = IO_STRB && (PORT_ID == PID_INT_STATUS);

  rat_interval_timer #(.PRESCALE(PRESCALE)) u_timer (
    .CLK    (CLK),
    .RESET  (RESET),
    .LD     (wr_reload),
    .RELOAD (OUT_PORT),
    .EXPIRE (expire)
  );

  // Events are OR-ed in after the clear so a same-cycle set beats W1C
  always_comb begin
    events                 = '0;
    events[ST_TIMER]       = expire;
    events[ST_BTN0 +: 4]   = btn_sync & ~btn_hist;
    w1c                    = wr_status ? OUT_PORT[NUM_SRC-1:0] : '0;
    status_nxt             = (status_q & ~w1c) | events;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= '0;
      btn_sync <= '0;
      btn_hist <= '0;
      leds_q   <= '0;
      sseg_q   <= '0;
      reload_q <= '0;
      mask_q   <= '0;
      status_q <= '0;
      int_q    <= 1'b0;
    end else begin
      sw_meta  <= SWITCHES;
      sw_sync  <= sw_meta;
      btn_meta <= BUTTONS;
      btn_sync <= btn_meta;
      btn_hist <= btn_sync;
      if (wr_leds)   leds_q   <= OUT_PORT;
      if (wr_sseg)   sseg_q   <= OUT_PORT;
      if (wr_reload) reload_q <= OUT_PORT;
      if (wr_mask)   mask_q   <= OUT_PORT[NUM_SRC-1:0];
      status_q <= status_nxt;
      int_q    <= |(status_q & mask_q);
    end
  end

  always_comb begin
    IN_PORT = 8'h00;
    case (PORT_ID)
      PID_SWITCHES:   IN_PORT = sw_sync;
      PID_BUTTONS:    IN_PORT = {4'b0000, btn_sync};
      PID_LEDS:       IN_PORT = leds_q;
      PID_TMR_RELOAD: IN_PORT = reload_q;
      PID_INT_MASK:   IN_PORT = {3'b000, mask_q};
      PID_INT_STATUS: IN_PORT = {3'b000, status_q};
      default:        IN_PORT = 8'h00;
    endcase
  end

  assign INT_CU   = int_q;
  assign LEDS     = leds_q;
  assign SSEG_VAL = sseg_q;

endmodule

// File: tb/tb_rat_io_bridge.sv
// tb/tb_rat_io_bridge.sv - directed plus randomized self-checking bench for rat_io_bridge
module tb_rat_io_bridge;

  localparam int P = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] OUT_PORT = '0;
  logic [7:0] PORT_ID = '0;
  logic       IO_STRB = 1'b0;
  logic [7:0] IN_PORT;
  logic       INT_CU;
  logic [7:0] SWITCHES = '0;
  logic [3:0] BUTTONS = '0;
  logic [7:0] LEDS;
  logic [7:0] SSEG_VAL;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  rat_io_bridge #(.PRESCALE(P)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .OUT_PORT (OUT_PORT),
    .PORT_ID  (PORT_ID),
    .IO_STRB  (IO_STRB),
    .IN_PORT  (IN_PORT),
    .INT_CU   (INT_CU),
    .SWITCHES (SWITCHES),
    .BUTTONS  (BUTTONS),
    .LEDS     (LEDS),
    .SSEG_VAL (SSEG_VAL)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [7:0] pid, input logic [7:0] d);
    PORT_ID  = pid;
    OUT_PORT = d;
    IO_STRB  = 1'b1;
    tick();
    IO_STRB  = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [7:0] pid, input logic [7:0] exp);
    PORT_ID = pid;
    #1;
    chk(tag, IN_PORT, exp);
  endtask

  // Polls status[0] once per cycle; t is the edge count at which it was first seen
  task automatic wait_expire(input int max, output int t, output bit ok);
    ok = 1'b0;
    t = 0;
    PORT_ID = 8'h32;
    for (int i = 0; i < max; i++) begin
      tick();
      if (IN_PORT[0]) begin
        t = cyc;
        ok = 1'b1;
        return;
      end
    end
  endtask

  function automatic bit is_mapped(input logic [7:0] pid);
    return pid inside {8'h20, 8'h21, 8'h40, 8'h81, 8'h30, 8'h31, 8'h32};
  endfunction

  initial begin
    int t0, t1, t2;
    bit ok, seen;
    logic [7:0] m_leds, m_sseg, m_mask, m_sw, pid, r, m_status;
    logic [3:0] b;

    tick();
    tick();
    RESET = 1'b0;

    rdchk("rst_leds", 8'h40, 8'h00);
    rdchk("rst_reload", 8'h30, 8'h00);
    rdchk("rst_mask", 8'h31, 8'h00);
    rdchk("rst_status", 8'h32, 8'h00);
    chk("rst_int", INT_CU, 1'b0);

    wr(8'h40, 8'hA5);
    chk("leds_out", LEDS, 8'hA5);
    rdchk("leds_rd", 8'h40, 8'hA5);
    rdchk("unmapped_rd", 8'h77, 8'h00);
    wr(8'h81, 8'h3C);
    chk("sseg_out", SSEG_VAL, 8'h3C);

    // Timer expiry every R*P cycles, interrupt one cycle behind status
    wr(8'h31, 8'h01);
    wr(8'h30, 8'h03);
    t0 = cyc;
    wait_expire(60, t1, ok);
    chk("tmr_first_seen", ok, 1'b1);
    chk("tmr_first_delay", t1 - t0, 3 * P);
    chk("tmr_int_lag", INT_CU, 1'b0);
    tick();
    chk("tmr_int_rise", INT_CU, 1'b1);
    wr(8'h32, 8'h01);
    chk("w1c_int_hold", INT_CU, 1'b1);
    tick();
    chk("w1c_int_fall", INT_CU, 1'b0);
    wait_expire(60, t2, ok);
    chk("tmr_second_seen", ok, 1'b1);
    chk("tmr_period", t2 - t1, 3 * P);

    // W1C lands on the very edge of the next expiry: set must win
    repeat (11) tick();
    wr(8'h32, 8'h01);
    rdchk("collide_status", 8'h32, 8'h01);
    chk("collide_int_a", INT_CU, 1'b1);
    tick();
    chk("collide_int_b", INT_CU, 1'b1);

    // R=0 stops the timer
    wr(8'h30, 8'h00);
    wr(8'h32, 8'h1F);
    PORT_ID = 8'h32;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (IN_PORT[0]) seen = 1'b1;
    end
    chk("r0_no_expire", seen, 1'b0);
    chk("r0_int_low", INT_CU, 1'b0);

    // Button edge latency and masking
    wr(8'h31, 8'h00);
    BUTTONS = 4'b0100;
    tick();
    tick();
    rdchk("btn_not_yet", 8'h32, 8'h00);
    tick();
    rdchk("btn_status", 8'h32, 8'h08);
    BUTTONS = 4'b0000;
    chk("btn_masked_int_a", INT_CU, 1'b0);
    tick();
    chk("btn_masked_int_b", INT_CU, 1'b0);
    wr(8'h31, 8'h08);
    chk("mask_int_lag", INT_CU, 1'b0);
    tick();
    chk("mask_int_rise", INT_CU, 1'b1);
    wr(8'h32, 8'h1F);
    tick();
    tick();

    // Randomized register traffic against a simple value model
    m_leds = LEDS;
    m_sseg = SSEG_VAL;
    for (int it = 0; it < 12; it++) begin
      m_leds = 8'($urandom);
      m_sseg = 8'($urandom);
      m_mask = 8'($urandom);
      m_sw   = 8'($urandom);
      wr(8'h40, m_leds);
      wr(8'h81, m_sseg);
      wr(8'h31, m_mask);
      do pid = 8'($urandom); while (is_mapped(pid));
      wr(pid, 8'($urandom));
      SWITCHES = m_sw;
      tick();
      tick();
      chk("rnd_leds", LEDS, m_leds);
      chk("rnd_sseg", SSEG_VAL, m_sseg);
      rdchk("rnd_leds_rd", 8'h40, m_leds);
      rdchk("rnd_mask_rd", 8'h31, {3'b000, m_mask[4:0]});
      rdchk("rnd_sw_rd", 8'h20, m_sw);
      rdchk("rnd_unmapped_rd", pid, 8'h00);
    end

    // Randomized button patterns: status and interrupt from mask & edges
    for (int it = 0; it < 6; it++) begin
      m_mask = 8'($urandom_range(0, 31));
      b = 4'($urandom_range(1, 15));
      wr(8'h31, m_mask);
      wr(8'h32, 8'h1F);
      tick();
      BUTTONS = b;
      repeat (4) tick();
      BUTTONS = 4'b0000;
      m_status = {3'b000, b, 1'b0};
      rdchk("rnd_btn_status", 8'h32, m_status);
      chk("rnd_btn_int", INT_CU, |(m_status & m_mask));
      rdchk("rnd_btn_sync", 8'h21, {4'b0000, b});
      repeat (3) tick();
      wr(8'h32, 8'h1F);
      tick();
      chk("rnd_btn_int_clr", INT_CU, 1'b0);
    end

    // Randomized reload values: expiry delay is R*P
    for (int it = 0; it < 4; it++) begin
      r = 8'($urandom_range(1, 6));
      wr(8'h30, 8'h00);
      wr(8'h32, 8'h1F);
      wr(8'h30, r);
      t0 = cyc;
      wait_expire(200, t1, ok);
      chk("rnd_tmr_seen", ok, 1'b1);
      chk("rnd_tmr_delay", t1 - t0, r * P);
      rdchk("rnd_reload_rd", 8'h30, r);
    end

    // Reset with every source pending
    wr(8'h30, 8'h01);
    wr(8'h31, 8'h1F);
    BUTTONS = 4'hF;
    repeat (4) tick();
    BUTTONS = 4'h0;
    repeat (4) tick();
    rdchk("pre_rst_status", 8'h32, 8'h1F);
    chk("pre_rst_int", INT_CU, 1'b1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("post_rst_int", INT_CU, 1'b0);
    chk("post_rst_leds", LEDS, 8'h00);
    chk("post_rst_sseg", SSEG_VAL, 8'h00);
    rdchk("post_rst_reload", 8'h30, 8'h00);
    rdchk("post_rst_mask", 8'h31, 8'h00);
    rdchk("post_rst_status", 8'h32, 8'h00);
    rdchk("post_rst_sw", 8'h20, 8'h00);
    repeat (6) tick();
    rdchk("post_rst_idle_status", 8'h32, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rat_io_bridge.md
# rat_io_bridge

Peripheral-side responder for the RAT MCU port bus: decodes `PORT_ID`/`IO_STRB` writes from `OUT`, supplies `IN_PORT` for `IN`, and drives `INT_CU`. Holds the board output latches (LEDs, seven-segment value), synchronizes switches and buttons, and contains a programmable interval timer. Interrupt sources are button rising edges and timer expiry, with a per-source mask and a write-1-to-clear status register. Instantiated beside `RAT_MCU` in the board top level.

## Interface
- `PRESCALE`, default 50000: clock cycles per timer tick; must be ≥ 2.
- `CLK` in 1: system clock, all state on rising edge.
- `RESET` in 1: synchronous, active-high; clears every register listed under Operation.
- `OUT_PORT` in 8: write data from the MCU.
- `PORT_ID` in 8: port address from the MCU.
- `IO_STRB` in 1: one-cycle write strobe from the MCU.
- `IN_PORT` out 8: read data to the MCU, combinational on `PORT_ID`.
- `INT_CU` out 1: interrupt request level to the MCU.
- `SWITCHES` in 8: asynchronous board switches.
- `BUTTONS` in 4: asynchronous board buttons.
- `LEDS` out 8: LED latch.
- `SSEG_VAL` out 8: seven-segment value latch.

## Operation
- Port map, write (on `IO_STRB`=1): 0x40 `LEDS`; 0x81 `SSEG_VAL`; 0x30 timer reload R; 0x31 mask[4:0]; 0x32 status W1C (bits of `OUT_PORT[4:0]` set to 1 clear matching status bits). Writes to other IDs are ignored.
- Port map, read: 0x20 synchronized switches; 0x21 synchronized buttons in [3:0], zeros above; 0x40 `LEDS` readback; 0x30 R; 0x31 {3'b0, mask}; 0x32 {3'b0, status}. Any other ID reads 0x00. Reads have no side effects.
- Status bits: [0] timer expired, [4:1] rising edge on `BUTTONS[3:0]`. Sticky until cleared.
- Set/clear collision: if a source event and a W1C for the same bit occur in the same cycle, set wins (bit ends at 1).
- `INT_CU` = registered OR of (status & mask); it stays high until the ISR clears every unmasked pending bit. Writing mask while status bits are pending raises/lowers `INT_CU` one cycle later.
- Inputs: `SWITCHES` and `BUTTONS` pass through two flops; buttons add a third history flop; an edge is sync2=1 and history=0. All these flops reset to 0, so a button held across reset release produces exactly one event.
- Timer: prescaler counts 0..PRESCALE−1 and emits a one-cycle tick at PRESCALE−1. An 8-bit down counter decrements on each tick; a tick with counter==1 sets status[0] and reloads R. Expiry period is R·PRESCALE cycles.
- Writing R: counter loads the new R and the prescaler resets to 0 in the same edge. R=0 stops the timer: counter is held at 0 and no expiry occurs. Writing the same R again restarts the period.
- Reset values: `LEDS`, `SSEG_VAL`, R, mask, status, counter, prescaler, sync/history flops and `INT_CU` all 0.

## Timing
- Write: register updates on the edge where `IO_STRB`=1; the new value is visible on outputs in the next cycle.
- Read: `IN_PORT` is valid in the same cycle `PORT_ID` is stable. The MCU captures it on the `IN` write-back edge.
- Button edge to status bit: set on the 3rd rising edge after the input is stable high. `INT_CU` rises one edge later, 4 cycles total.
- Timer expiry to `INT_CU`: status[0] is set on the tick edge; `INT_CU` rises 1 cycle later.
- W1C to `INT_CU` low: status clears on the strobe edge; `INT_CU` falls on the next edge.
- `RESET` mid-count or with an interrupt pending: everything returns to reset values on that edge, and `INT_CU` is 0 in the following cycle.

## Structure
- Package `rat_io_pkg`: port-ID localparams (`PID_SWITCHES`, `PID_BUTTONS`, `PID_LEDS`, `PID_SSEG`, `PID_TMR_RELOAD`, `PID_INT_MASK`, `PID_INT_STATUS`) and status bit-index constants.
- Sub-module `rat_interval_timer`: params `PRESCALE`; ports `CLK`, `RESET`, `LD`, `RELOAD[7:0]`, output `EXPIRE` (one-cycle pulse). The bridge owns decode, sync, status, mask and the interrupt.

## Test plan
- After reset, PID 0x40/0x30/0x31/0x32 read 0x00, `INT_CU`=0; write 0xA5 to 0x40 → `LEDS`=0xA5 next cycle, read of 0x40 returns 0xA5, unmapped 0x77 reads 0x00.
- `PRESCALE`=4, write 3 to 0x30, mask 0x01 → status[0] sets exactly 12 cycles after the strobe and `INT_CU` rises 1 cycle later; write 0x01 to 0x32 → `INT_CU` low next cycle, next expiry 12 cycles after the previous one.
- Pulse `BUTTONS[2]` high with mask 0x00 → status reads 0x08, `INT_CU` stays 0; then write mask 0x08 → `INT_CU`=1 next cycle.
- Make status[0] expiry coincide with a W1C 0x01 strobe → status[0] remains 1 and `INT_CU` stays high.
- Write R=0 while counting → no further expiry over 100 cycles. Assert `RESET` with status 0x1F pending → all registers 0 and `INT_CU`=0 on the next cycle.
